// File: rtl/seq_det_ctrl.sv
// Word-to-serial sequencer for a clear/enable Moore sequence detector.
// Shifts each accepted word out MSB-first and reports the number of detector hits.
module seq_det_ctrl #(
  parameter int W     = 8,
  parameter bit CARRY = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     det_x,
  output logic                     det_en,
  output logic                     det_clr,
  input  logic                     det_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(W+1)-1:0]   out_count,
  output logic                     out_hit
);

  localparam int KW = $clog2(W);
  localparam int CW = $clog2(W+1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_REPORT} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            det_x_q, det_x_d;
  logic            det_en_q, det_en_d;
  logic            det_clr_q, det_clr_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic            out_hit_q, out_hit_d;

  // NOTE: sequential state uses non-blocking assignments; the comb blocks below use blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      det_x_q     <= 1'b0;
      det_en_q    <= 1'b0;
      det_clr_q   <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      det_x_q     <= det_x_d;
      det_en_q    <= det_en_d;
      det_clr_q   <= det_clr_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_hit_q   <= out_hit_d;
    end
  end

  // NOTE: every comb output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = CARRY ? S_SHIFT : S_CLEAR;
      S_CLEAR:  state_d = S_SHIFT;
      S_SHIFT:  if (k_q == KW'(W-1)) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_REPORT;
      S_REPORT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from the next state.
  always_comb begin
    logic [W-1:0] src;
    src         = (state_q == S_IDLE) ? in_data : sh_q;
    sh_d        = sh_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    det_x_d     = 1'b0;
    out_count_d = out_count_q;
    out_hit_d   = out_hit_q;

    if (state_q == S_IDLE && in_valid) begin
      sh_d  = in_data;
      cnt_d = '0;
    end

    if (state_d == S_SHIFT) begin
      det_x_d = src[W-1];
      sh_d    = src << 1;
      k_d     = (state_q == S_SHIFT) ? k_q + KW'(1) : '0;
    end

    // det_z lags the fed bit by one cycle; at k=0 it still shows the pre-word state.
    if ((state_q == S_SHIFT && k_q != '0) || state_q == S_DRAIN)
      cnt_d = cnt_q + CW'(det_z);

    if (state_q == S_DRAIN) begin
      out_count_d = cnt_d;
      out_hit_d   = (cnt_d != '0);
    end

    det_en_d    = (state_d == S_SHIFT);
    det_clr_d   = (state_d == S_CLEAR);
    out_valid_d = (state_d == S_REPORT);
  end

  assign in_ready  = (state_q == S_IDLE);
  assign det_x     = det_x_q;
  assign det_en    = det_en_q;
  assign det_clr   = det_clr_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_hit   = out_hit_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: one instance per CARRY setting, each driving a behavioural
// overlapping "101" Moore detector; results are compared with a bit-stream reference model.
module tb_seq_det_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    in_valid, in_ready, det_x, det_en, det_clr, det_z;
  logic [1:0]    out_valid, out_ready, out_hit;
  logic [W-1:0]  in_data [2];
  logic [CW-1:0] out_count [2];
  logic [2:0]    hist [2];

  seq_det_ctrl #(.W(W), .CARRY(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .det_x(det_x[0]), .det_en(det_en[0]), .det_clr(det_clr[0]), .det_z(det_z[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_count(out_count[0]), .out_hit(out_hit[0])
  );

  seq_det_ctrl #(.W(W), .CARRY(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .det_x(det_x[1]), .det_en(det_en[1]), .det_clr(det_clr[1]), .det_z(det_z[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_count(out_count[1]), .out_hit(out_hit[1])
  );

  // Detector: z is high when the last three enabled bits were 1,0,1.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (det_clr[c])     hist[c] <= 3'b000;
      else if (det_en[c]) hist[c] <= {hist[c][1:0], det_x[c]};
    end
  end
  assign det_z = {hist[1] == 3'b101, hist[0] == 3'b101};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: bit streams seen by each detector since its last clear.
  bit s0[$];
  bit s1[$];

  function automatic int model_word(input int c, input logic [W-1:0] d);
    bit s[$];
    int hits = 0;
    if (c == 1) s = s1;
    for (int i = W-1; i >= 0; i--) begin
      s.push_back(d[i]);
      if (s.size() >= 3 && s[s.size()-3] == 1'b1 && s[s.size()-2] == 1'b0 && s[s.size()-1] == 1'b1)
        hits++;
    end
    while (s.size() > 2) void'(s.pop_front());
    if (c == 1) s1 = s;
    return hits;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s0.delete();
    s1.delete();
  endtask

  // Sends one word on channel c, holds out_ready low for 'hold' report cycles, then hands it off.
  task automatic do_word(input int c, input logic [W-1:0] d, input int hold,
                         output logic [CW-1:0] cnt, output logic hit, output int lat,
                         output logic [W-1:0] xs, output int nx);
    int guard = 0;
    @(negedge clk);
    while (!in_ready[c] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid[c] = 1'b1;
    in_data[c]  = d;
    @(posedge clk);
    #1;
    in_valid[c] = 1'b0;
    in_data[c]  = W'($urandom);
    lat = 0;
    nx  = 0;
    xs  = '0;
    while (!out_valid[c] && lat < 40) begin
      if (det_en[c]) begin
        xs = {xs[W-2:0], det_x[c]};
        nx++;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    cnt = out_count[c];
    hit = out_hit[c];
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid[c], 1);
      check("hold_count", out_count[c], cnt);
      check("hold_in_ready", in_ready[c], 0);
      check("hold_det_en", det_en[c], 0);
    end
    out_ready[c] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[c] = 1'b0;
    check("valid_drop", out_valid[c], 0);
    check("ready_back", in_ready[c], 1);
  endtask

  typedef struct {
    int           c;
    logic [W-1:0] d;
    int           exp;
    int           hold;
  } vec_t;

  initial begin
    vec_t          tbl [12];
    logic [CW-1:0] cnt;
    logic          hit;
    int            lat, nx;
    logic [W-1:0]  xs;

    tbl[0]  = '{0, 8'b1010_1010, 3, 0};
    tbl[1]  = '{0, 8'h00,        0, 0};
    tbl[2]  = '{0, 8'hFF,        0, 0};
    tbl[3]  = '{0, 8'b0000_0010, 0, 0};
    tbl[4]  = '{0, 8'b1000_0000, 0, 0};
    tbl[5]  = '{0, 8'h2D,        2, 0};
    tbl[6]  = '{0, 8'hA5,        2, 5};
    tbl[7]  = '{0, 8'h55,        3, 1};
    tbl[8]  = '{1, 8'b0000_0010, 0, 0};
    tbl[9]  = '{1, 8'b1000_0000, 1, 0};
    tbl[10] = '{1, 8'h05,        1, 2};
    tbl[11] = '{1, 8'h40,        1, 0};

    rst        = 1'b1;
    in_valid   = '0;
    out_ready  = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    do_reset();

    check("rst_in_ready", in_ready, 2'b11);
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_det_clr", det_clr, 2'b11);
    check("rst_det_en", det_en, 2'b00);
    check("rst_det_x", det_x, 2'b00);
    check("rst_count", out_count[0], 0);
    check("rst_hit", out_hit, 2'b00);
    @(posedge clk);
    #1;
    check("clr_released", det_clr, 2'b00);

    foreach (tbl[i]) begin
      do_word(tbl[i].c, tbl[i].d, tbl[i].hold, cnt, hit, lat, xs, nx);
      check($sformatf("tbl%0d_count", i), cnt, tbl[i].exp);
      check($sformatf("tbl%0d_hit", i), hit, tbl[i].exp != 0);
      check($sformatf("tbl%0d_latency", i), lat, (tbl[i].c == 1) ? W+1 : W+2);
      check($sformatf("tbl%0d_nbits", i), nx, W);
      check($sformatf("tbl%0d_bits", i), xs, tbl[i].d);
    end

    // Reset in the middle of a word (SHIFT, k=4).
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'b1010_1010;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("k4_det_en", det_en[0], 1);
    check("k4_det_x", det_x[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s0.delete();
    s1.delete();
    check("mid_rst_in_ready", in_ready[0], 1);
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_det_clr", det_clr, 2'b11);
    check("mid_rst_det_en", det_en[0], 0);
    do_word(0, 8'b1010_1010, 0, cnt, hit, lat, xs, nx);
    check("after_rst_count", cnt, 3);
    check("after_rst_latency", lat, W+2);

    // in_valid held high with a new word always waiting.
    begin
      logic [W-1:0]  wl [5];
      int            acc[$];
      logic [CW-1:0] got[$];
      int            idx = 0;
      bit            take;
      foreach (wl[i]) wl[i] = W'($urandom);
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[0]   = wl[0];
      for (int cyc = 0; cyc < 80; cyc++) begin
        @(negedge clk);
        take = in_ready[0] && in_valid[0];
        if (take) acc.push_back(cyc);
        if (out_valid[0]) got.push_back(out_count[0]);
        @(posedge clk);
        #1;
        if (take) begin
          idx++;
          if (idx < 5) in_data[0] = wl[idx];
          else         in_valid[0] = 1'b0;
        end
      end
      out_ready[0] = 1'b0;
      check("stream_accepts", acc.size(), 5);
      check("stream_results", got.size(), 5);
      for (int i = 1; i < 5 && i < acc.size(); i++)
        check($sformatf("stream_spacing%0d", i), acc[i] - acc[i-1], W+4);
      for (int i = 0; i < 5 && i < got.size(); i++)
        check($sformatf("stream_count%0d", i), got[i], model_word(0, wl[i]));
    end

    // Randomized words on both channels against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int           c;
      int           exp;
      logic [W-1:0] d;
      c   = i % 2;
      d   = W'($urandom);
      exp = model_word(c, d);
      do_word(c, d, $urandom_range(0, 3), cnt, hit, lat, xs, nx);
      check($sformatf("rnd%0d_count", i), cnt, exp);
      check($sformatf("rnd%0d_hit", i), hit, exp != 0);
      check($sformatf("rnd%0d_latency", i), lat, (c == 1) ? W+1 : W+2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
